// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, latencies and decode helpers for the multiply/divide unit.
// MDU_MADD_EN enables the multiply-accumulate ops; otherwise their codes decode as idle.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  localparam logic [3:0] MDU_MULT_CYCLES = 4'd5;
  localparam logic [3:0] MDU_DIV_CYCLES  = 4'd10;

  function automatic logic mdu_is_long(input mdu_op_e op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: mdu_is_long = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: mdu_is_long = 1'b1;
`endif
      default: mdu_is_long = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] mdu_cycles(input mdu_op_e op);
    mdu_cycles = (op == MDU_DIV || op == MDU_DIVU) ? MDU_DIV_CYCLES : MDU_MULT_CYCLES;
  endfunction

  // Signed ops sign-extend their operands; the U variants zero-extend.
  function automatic logic mdu_is_signed(input mdu_op_e op);
    mdu_is_signed = (op == MDU_MULT || op == MDU_DIV || op == MDU_MADD || op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Busy sequencer: IDLE -> RUN (down-counter) -> IDLE, pulsing commit on the last cycle.
// Registered busy; starts are only honoured in IDLE.
module mdu_ctrl
  import mult_div_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] cycles_i,
  output logic       busy_o,
  output logic       commit_o
);

  mdu_state_e state_q;
  logic [3:0] cnt_q;
  logic       busy_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MDU_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            state_q <= MDU_RUN;
            cnt_q   <= cycles_i;
            busy_q  <= 1'b1;
          end
        end
        MDU_RUN: begin
          if (cnt_q == 4'd1) begin
            state_q <= MDU_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign commit_o = (state_q == MDU_RUN) && (cnt_q == 4'd1);

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: operands latched at accept, result committed on the final busy edge.
// Optional MADD/MSUB family controlled by MDU_MADD_EN.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic [3:0]  E_mdu_op,
  input  logic        E_mdu_start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_mdu_result
);

  mdu_op_e     op;
  mdu_op_e     op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic        accept, long_start, commit;
  logic [63:0] a_ext, b_ext, prod, quot, rem;

  assign op         = mdu_op_e'(E_mdu_op);
  assign accept     = E_mdu_start && !busy;
  assign long_start = accept && mdu_is_long(op);

  mdu_ctrl u_ctrl (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (long_start),
    .cycles_i (mdu_cycles(op)),
    .busy_o   (busy),
    .commit_o (commit)
  );

  always_comb begin
    a_ext = mdu_is_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext = mdu_is_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    // Low 64 bits of the product are the same whether the operands are read as signed or not.
    prod  = a_ext * b_ext;
    quot  = 64'd0;
    rem   = 64'd0;
    if (b_q != 32'd0) begin
      if (mdu_is_signed(op_q)) begin
        quot = $signed(a_ext) / $signed(b_ext);
        rem  = $signed(a_ext) % $signed(b_ext);
      end else begin
        quot = a_ext / b_ext;
        rem  = a_ext % b_ext;
      end
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept && op == MDU_MTHI) hi_d = E_rs_data;
    if (accept && op == MDU_MTLO) lo_d = E_rs_data;
    if (commit) begin
      case (op_q)
        MDU_MULT, MDU_MULTU: {hi_d, lo_d} = prod;
        MDU_DIV, MDU_DIVU: begin
          // Divide by zero leaves HI/LO untouched.
          if (b_q != 32'd0) begin
            lo_d = quot[31:0];
            hi_d = rem[31:0];
          end
        end
`ifdef MDU_MADD_EN
        MDU_MADD, MDU_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod;
        MDU_MSUB, MDU_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= MDU_NONE;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (long_start) begin
        a_q  <= E_rs_data;
        b_q  <= E_rt_data;
        op_q <= op;
      end
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;
  assign E_mdu_result = (op == MDU_MFHI) ? hi_q :
                        (op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port E_rs_data, input, 32 bits: forwarded rs operand from the execute stage.
REQ-004 SHALL have port E_rt_data, input, 32 bits: forwarded rt operand from the execute stage.
REQ-005 SHALL have port E_mdu_op, input, 4 bits: operation code (package enum); MDU_NONE=0 means idle.
REQ-006 SHALL have port E_mdu_start, input, 1 bit: qualifies E_mdu_op for one cycle.
REQ-007 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-008 SHALL have port HI, output, 32 bits: architectural HI register.
REQ-009 SHALL have port LO, output, 32 bits: architectural LO register.
REQ-010 SHALL have port E_mdu_result, output, 32 bits: HI when op=MFHI, LO when op=MFLO, else 0; combinational.

Function
REQ-011 SHALL accept an op at a rising edge when E_mdu_start=1, busy=0 and reset=0; the edge at which it is accepted is T0.
REQ-012 SHALL, for MULT/MULTU, hold busy=1 from T0+1 through T0+5; HI/LO take the 64-bit product at edge T0+5, and busy falls at the same edge.
REQ-013 SHALL, for DIV/DIVU, hold busy=1 from T0+1 through T0+10; LO takes the quotient and HI the remainder at edge T0+10.
REQ-014 SHALL latch operands at T0, so that later changes to E_rs_data/E_rt_data do not affect the result.
REQ-015 SHALL sign-extend operands to 64 bits for MULT/DIV and zero-extend them for MULTU/DIVU.
REQ-016 SHALL truncate signed division toward zero; the remainder takes the sign of the dividend.
REQ-017 SHALL, on divide by zero, leave HI/LO unchanged while still running the full 10-cycle busy period.
REQ-018 SHALL, for MTHI/MTLO, write E_rs_data to HI/LO at T0 with no busy period.
REQ-019 SHALL ignore any start (including MTHI/MTLO) while busy=1; the hazard logic stalls on start||busy.
REQ-020 SHALL treat MFHI/MFLO/NONE as not starting anything and leave busy unchanged.
REQ-021 SHALL use a state machine IDLE -> RUN (down-counter loaded with 5 or 10) -> IDLE; the counter reaching 1 commits the result and returns to IDLE.
REQ-022 SHALL present HI/LO as registered outputs; MFHI/MFLO issued in the commit cycle read the old value, because the hazard logic stalls them.

Reset
REQ-023 SHALL clear HI, LO, busy, the counter and the latched operands to 0 when reset=1 at an edge, and return the state machine to IDLE.
REQ-024 SHALL, on reset mid-operation, discard the in-flight result; nothing commits after reset.

Configuration
REQ-025 SHALL, when MDU_MADD_EN is defined, support MADD/MADDU/MSUB/MSUBU: {HI,LO} +/- product (signed or unsigned per REQ-015), with a 5-cycle latency, computed modulo 2^64.
REQ-026 SHALL, when MDU_MADD_EN is undefined, treat those op codes as MDU_NONE (no start, no busy, HI/LO unchanged).

Structure
REQ-027 SHALL take the op enum (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU) and the latency constants MDU_MULT_CYCLES=5 and MDU_DIV_CYCLES=10 from the shared macros package.
REQ-028 SHALL implement the counter and state machine in one sub-module, mdu_ctrl; the arithmetic stays in the parent.

Verification
REQ-029 SHALL cover: MULT rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-030 SHALL cover: MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-031 SHALL cover: DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> busy high 10 cycles, HI/LO unchanged.
REQ-032 SHALL cover: MTLO 0x12345678 then MFLO -> LO updates next edge and E_mdu_result=0x12345678; MTHI during busy -> ignored.
REQ-033 SHALL cover: reset asserted at cycle 3 of a DIV -> busy=0, HI=LO=0, and no commit at T0+10.
REQ-034 SHALL cover, with MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=0x00000001, LO=0x00000000.
